// File: rtl/mem_port_arbiter.sv
// Purpose: arbitrates instruction fetch and data access onto one fixed-latency memory port.
// Latency: grant is combinational; the response returns LAT cycles after the grant cycle.
// Backpressure: one access outstanding; losers see gnt=0 (stall_f for fetch) and hold their request.
// Optional build macro ARB_ROUND_ROBIN_EN: strict alternation instead of data-priority with starvation guard.
module mem_port_arbiter #(
  parameter int LAT        = 2,
  parameter int STARVE_MAX = 2
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        flush,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_en,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_be,
  input  logic [31:0] m_rdata,
  output logic        stall_f
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        own_data_q, own_data_d;   // 1: outstanding access belongs to the data port
  logic        cancel_q, cancel_d;       // outstanding fetch was redirected away
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
  logic        last_data_q, last_data_d; // 1: the most recent grant went to data
`else
  logic [2:0]  starve_q, starve_d;       // consecutive data grants while fetch waited
`endif

  logic resp;
  logic can_grant;
  logic fetch_win;

  // State register; reset discards any outstanding access.
  always_ff @(posedge clk or negedge srst) begin
    if (!srst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      own_data_q  <= 1'b0;
      cancel_q    <= 1'b0;
      if_rdata_q  <= 32'd0;
      d_rdata_q   <= 32'd0;
`ifdef ARB_ROUND_ROBIN_EN
      last_data_q <= 1'b0;
`else
      starve_q    <= 3'd0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      own_data_q  <= own_data_d;
      cancel_q    <= cancel_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_data_q <= last_data_d;
`else
      starve_q    <= starve_d;
`endif
    end
  end

  // Arbitration, memory strobe muxing, response routing and next-state logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    own_data_d = own_data_q;
    cancel_d   = cancel_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_data_d = last_data_q;
`else
    starve_d    = starve_q;
`endif
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    m_we      = 1'b0;
    m_addr    = 32'd0;
    m_wdata   = 32'd0;
    m_be      = 4'd0;

    resp = (state_q == BUSY) && (cnt_q == 3'd0);
    // Grants are held off while reset is asserted so no strobe leaks out.
    can_grant = srst && ((state_q == IDLE) || resp);

`ifdef ARB_ROUND_ROBIN_EN
    fetch_win = if_req && (!d_req || last_data_q);
`else
    fetch_win = if_req && (!d_req || (starve_q == 3'(STARVE_MAX)));
`endif

    if (can_grant) begin
      if_gnt = fetch_win;
      d_gnt  = d_req && !fetch_win;
    end

    // Response routing; a redirect in the response cycle also suppresses the fetch word.
    if (resp) begin
      if_rvalid = !own_data_q && !cancel_q && !flush;
      d_rvalid  = own_data_q;
      state_d   = IDLE;
      cancel_d  = 1'b0;
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q - 3'd1;
      if (flush && !own_data_q) cancel_d = 1'b1;
    end

    if (if_rvalid) if_rdata_d = m_rdata;
    if (d_rvalid)  d_rdata_d  = m_rdata;

    if (if_gnt) begin
      m_addr     = if_addr;
      m_be       = 4'hF;
      state_d    = BUSY;
      cnt_d      = 3'(LAT - 1);
      own_data_d = 1'b0;
      cancel_d   = flush;
`ifdef ARB_ROUND_ROBIN_EN
      last_data_d = 1'b0;
`else
      starve_d    = 3'd0;
`endif
    end else if (d_gnt) begin
      m_we       = d_we;
      m_addr     = d_addr;
      m_wdata    = d_wdata;
      m_be       = d_be;
      state_d    = BUSY;
      cnt_d      = 3'(LAT - 1);
      own_data_d = 1'b1;
      cancel_d   = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_data_d = 1'b1;
`else
      if (if_req && starve_q != 3'd7) starve_d = starve_q + 3'd1;
`endif
    end
  end

  assign m_en     = if_gnt | d_gnt;
  assign stall_f  = if_req & ~if_gnt;
  assign if_rdata = if_rvalid ? m_rdata : if_rdata_q;
  assign d_rdata  = d_rvalid  ? m_rdata : d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with LAT=2, STARVE_MAX=2 (data-priority build).
// Memory model returns addr + 0x1000_0000 two cycles after each m_en cycle.
module tb_mem_port_arbiter;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        srst;
  logic        if_req, flush, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, m_en, m_we, stall_f;
  logic [31:0] if_rdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;
  logic [31:0] p0, p1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.LAT(LAT), .STARVE_MAX(2)) dut (
    .clk(clk), .srst(srst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .flush(flush),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_rdata(m_rdata), .stall_f(stall_f)
  );

  // Fixed two-cycle memory
  always @(posedge clk) begin
    p0 <= m_en ? (m_addr + 32'h1000_0000) : 32'h0BAD_0BAD;
    p1 <= p0;
  end
  assign m_rdata = p1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    srst = 1'b0; if_req = 1'b1; d_req = 1'b1; d_addr = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if ({if_gnt, d_gnt, m_en, if_rvalid, d_rvalid, stall_f} !== 6'b000001) begin errors++; $display("FAIL reset_ctl got %b exp 000001", {if_gnt, d_gnt, m_en, if_rvalid, d_rvalid, stall_f}); end
    checks++; if ({if_rdata, d_rdata} !== 64'd0) begin errors++; $display("FAIL reset_rdata got %h exp 0", {if_rdata, d_rdata}); end
    tick(); srst = 1'b1; if_req = 1'b0; d_req = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h0;                                  // t0
    @(negedge clk);
    checks++; if ({if_gnt, d_gnt, m_en, m_we, stall_f} !== 5'b10100) begin errors++; $display("FAIL fetch_t0_ctl got %b exp 10100", {if_gnt, d_gnt, m_en, m_we, stall_f}); end
    checks++; if ({m_be, m_addr} !== {4'hF, 32'h0}) begin errors++; $display("FAIL fetch_t0_bus got %h exp f00000000", {m_be, m_addr}); end
    tick(); if_addr = 32'h4;                                         // t1
    @(negedge clk);
    checks++; if ({if_gnt, if_rvalid, stall_f} !== 3'b001) begin errors++; $display("FAIL fetch_t1 got %b exp 001", {if_gnt, if_rvalid, stall_f}); end
    tick();                                                          // t2
    @(negedge clk);
    checks++; if ({if_gnt, if_rvalid} !== 2'b11) begin errors++; $display("FAIL fetch_t2_ctl got %b exp 11", {if_gnt, if_rvalid}); end
    checks++; if (if_rdata !== 32'h1000_0000) begin errors++; $display("FAIL fetch_t2_rdata got %h exp 10000000", if_rdata); end
    checks++; if (m_addr !== 32'h4) begin errors++; $display("FAIL fetch_t2_addr got %h exp 4", m_addr); end
    tick(); if_req = 1'b0;                                           // t3
    @(negedge clk);
    checks++; if ({if_rvalid, if_rdata} !== {1'b0, 32'h1000_0000}) begin errors++; $display("FAIL fetch_t3_hold got %h exp 010000000", {if_rvalid, if_rdata}); end
    tick();                                                          // t4
    @(negedge clk);
    checks++; if ({if_rvalid, if_rdata} !== {1'b1, 32'h1000_0004}) begin errors++; $display("FAIL fetch_t4 got %h exp 110000004", {if_rvalid, if_rdata}); end
    tick();
  endtask

  task automatic test_priority();
    if_req = 1'b1; if_addr = 32'h8; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_be = 4'hF;  // t0
    @(negedge clk);
    checks++; if ({if_gnt, d_gnt, m_en, m_we, stall_f} !== 5'b01101) begin errors++; $display("FAIL prio_t0 got %b exp 01101", {if_gnt, d_gnt, m_en, m_we, stall_f}); end
    checks++; if (m_addr !== 32'h100) begin errors++; $display("FAIL prio_t0_addr got %h exp 100", m_addr); end
    tick();                                                          // t1
    @(negedge clk);
    checks++; if ({if_gnt, d_gnt, stall_f} !== 3'b001) begin errors++; $display("FAIL prio_t1 got %b exp 001", {if_gnt, d_gnt, stall_f}); end
    tick();                                                          // t2
    @(negedge clk);
    checks++; if ({if_gnt, d_gnt, d_rvalid, if_rvalid, stall_f} !== 5'b01101) begin errors++; $display("FAIL prio_t2 got %b exp 01101", {if_gnt, d_gnt, d_rvalid, if_rvalid, stall_f}); end
    checks++; if (d_rdata !== 32'h1000_0100) begin errors++; $display("FAIL prio_t2_rdata got %h exp 10000100", d_rdata); end
    tick();                                                          // t3
    @(negedge clk);
    checks++; if ({if_gnt, d_gnt, d_rvalid, stall_f} !== 4'b0001) begin errors++; $display("FAIL prio_t3 got %b exp 0001", {if_gnt, d_gnt, d_rvalid, stall_f}); end
    tick();                                                          // t4: third arbitration
    @(negedge clk);
    checks++; if ({if_gnt, d_gnt, d_rvalid, stall_f} !== 4'b1010) begin errors++; $display("FAIL prio_t4 got %b exp 1010", {if_gnt, d_gnt, d_rvalid, stall_f}); end
    checks++; if ({m_be, m_we, m_addr} !== {4'hF, 1'b0, 32'h8}) begin errors++; $display("FAIL prio_t4_bus got %h exp 1e00000008", {m_be, m_we, m_addr}); end
    tick(); if_req = 1'b0; d_req = 1'b0;                             // t5
    @(negedge clk);
    checks++; if ({if_rvalid, d_rvalid, if_gnt, d_gnt} !== 4'b0000) begin errors++; $display("FAIL prio_t5 got %b exp 0000", {if_rvalid, d_rvalid, if_gnt, d_gnt}); end
    tick();                                                          // t6
    @(negedge clk);
    checks++; if ({if_rvalid, d_rvalid, if_rdata} !== {2'b10, 32'h1000_0008}) begin errors++; $display("FAIL prio_t6 got %h exp 210000008", {if_rvalid, d_rvalid, if_rdata}); end
    tick();
  endtask

  task automatic test_flush();
    if_req = 1'b1; if_addr = 32'h20;                                 // t0
    @(negedge clk);
    checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL flush_t0 got %b exp 1", if_gnt); end
    tick(); if_addr = 32'h40; flush = 1'b1;                          // t1
    @(negedge clk);
    checks++; if ({if_gnt, stall_f} !== 2'b01) begin errors++; $display("FAIL flush_t1 got %b exp 01", {if_gnt, stall_f}); end
    tick(); flush = 1'b0;                                            // t2
    @(negedge clk);
    checks++; if ({if_rvalid, if_gnt} !== 2'b01) begin errors++; $display("FAIL flush_t2_ctl got %b exp 01", {if_rvalid, if_gnt}); end
    checks++; if ({if_rdata, m_addr} !== {32'h1000_0008, 32'h40}) begin errors++; $display("FAIL flush_t2_data got %h exp 1000000800000040", {if_rdata, m_addr}); end
    tick(); if_req = 1'b0;                                           // t3
    tick();                                                          // t4
    @(negedge clk);
    checks++; if ({if_rvalid, if_rdata} !== {1'b1, 32'h1000_0040}) begin errors++; $display("FAIL flush_t4 got %h exp 110000040", {if_rvalid, if_rdata}); end
    tick();
    // Redirect in the same cycle as the grant cancels the new fetch
    if_req = 1'b1; if_addr = 32'h50; flush = 1'b1;                   // t0
    @(negedge clk);
    checks++; if ({if_gnt, m_en} !== 2'b11) begin errors++; $display("FAIL flushg_t0 got %b exp 11", {if_gnt, m_en}); end
    tick(); if_req = 1'b0; flush = 1'b0;                             // t1
    tick();                                                          // t2
    @(negedge clk);
    checks++; if ({if_rvalid, if_rdata} !== {1'b0, 32'h1000_0040}) begin errors++; $display("FAIL flushg_t2 got %h exp 010000040", {if_rvalid, if_rdata}); end
    tick();
  endtask

  task automatic test_store();
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_wdata = 32'hDEAD_BEEF; d_addr = 32'h200;  // t0
    @(negedge clk);
    checks++; if ({d_gnt, if_gnt, m_en, m_we, m_be} !== 8'b1011_0011) begin errors++; $display("FAIL store_t0_ctl got %b exp 10110011", {d_gnt, if_gnt, m_en, m_we, m_be}); end
    checks++; if ({m_wdata, m_addr} !== {32'hDEAD_BEEF, 32'h200}) begin errors++; $display("FAIL store_t0_bus got %h exp deadbeef00000200", {m_wdata, m_addr}); end
    tick(); d_req = 1'b0; d_we = 1'b0;                               // t1
    @(negedge clk);
    checks++; if ({d_rvalid, if_rvalid} !== 2'b00) begin errors++; $display("FAIL store_t1 got %b exp 00", {d_rvalid, if_rvalid}); end
    tick();                                                          // t2
    @(negedge clk);
    checks++; if ({d_rvalid, if_rvalid} !== 2'b10) begin errors++; $display("FAIL store_t2 got %b exp 10", {d_rvalid, if_rvalid}); end
    tick();                                                          // t3
    @(negedge clk);
    checks++; if ({d_rvalid, if_rvalid} !== 2'b00) begin errors++; $display("FAIL store_t3 got %b exp 00", {d_rvalid, if_rvalid}); end
    tick();
  endtask

  task automatic test_reset_mid();
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h300;        // t0
    @(negedge clk);
    checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL rstmid_t0 got %b exp 1", d_gnt); end
    tick(); srst = 1'b0; d_addr = 32'h304;                           // t1
    #1;
    checks++; if ({if_gnt, d_gnt, m_en, m_we, if_rvalid, d_rvalid, stall_f} !== 7'b0) begin errors++; $display("FAIL rstmid_ctl got %b exp 0000000", {if_gnt, d_gnt, m_en, m_we, if_rvalid, d_rvalid, stall_f}); end
    checks++; if ({if_rdata, d_rdata, m_addr, m_be} !== 100'd0) begin errors++; $display("FAIL rstmid_data got %h exp 0", {if_rdata, d_rdata, m_addr, m_be}); end
    tick(); srst = 1'b1;                                             // t2: first cycle after release
    @(negedge clk);
    checks++; if ({d_gnt, d_rvalid} !== 2'b10) begin errors++; $display("FAIL rstmid_t2 got %b exp 10", {d_gnt, d_rvalid}); end
    checks++; if (m_addr !== 32'h304) begin errors++; $display("FAIL rstmid_t2_addr got %h exp 304", m_addr); end
    tick(); d_req = 1'b0;                                            // t3
    @(negedge clk);
    checks++; if ({d_rvalid, d_rdata} !== 33'd0) begin errors++; $display("FAIL rstmid_t3 got %h exp 0", {d_rvalid, d_rdata}); end
    tick();                                                          // t4
    @(negedge clk);
    checks++; if ({d_rvalid, d_rdata} !== {1'b1, 32'h1000_0304}) begin errors++; $display("FAIL rstmid_t4 got %h exp 110000304", {d_rvalid, d_rdata}); end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    srst = 1'b0; if_req = 1'b0; if_addr = 32'h0; flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
    test_reset();
    test_fetch();
    test_priority();
    test_flush();
    test_store();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
